result_bcd_converter: RTL
=========================

Name: result_bcd_converter

Overview:
- Downstream stage of the simple calculator: consumes the 17-bit result `C` when the calculator signals Done.
- Converts the result to packed BCD digits for the display driver.
- Uses a sequential double-dabble (shift-and-add-3) converter, one bit per clock, with a start/busy/valid handshake.
- Holds the last converted value stable until a new conversion completes.

Parameters:
WIDTH, 17, bit width of the binary input (matches calculator result C).
DIGITS, 6, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH (not checked in RTL).

Ports:
Clk  input  1  system clock; all state changes on rising edge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  request conversion of Bin; sampled only in IDLE or DONE.
Bin  input  WIDTH  binary value to convert; captured on the accepting Start edge only.
Busy  output  1  high while a conversion is in progress.
Valid  output  1  high when Bcd holds a completed result; level, not pulse.
Bcd  output  4*DIGITS  packed BCD result; Bcd[3:0] = ones digit, Bcd[7:4] = tens digit, and so on.

Behaviour:
- Clock and reset: one clock (Clk). Reset is synchronous and active-high; it is sampled only on the Clk rising edge.
- Reset values: state=IDLE, Busy=0, Valid=0, Bcd=0, shift register and bit counter = 0. Reset overrides all other inputs on the same edge.
- States: IDLE, SHIFT, DONE (one-hot or binary encoding, implementer's choice).
- IDLE:
  - Start=1 loads the shift register: low WIDTH bits = Bin, BCD scratch = 0.
  - Loads counter = WIDTH and goes to SHIFT; Busy=1 from the next cycle.
  - Start=0 stays in IDLE.
- SHIFT, each cycle:
  - Every scratch nibble >= 5 gets +3 (all nibbles adjusted in parallel, combinationally).
  - Then the whole {scratch, binary} register shifts left by 1, and the counter decrements.
- SHIFT exit: on the edge where the counter goes 1 -> 0:
  - Bcd <= the post-shift scratch.
  - Valid <= 1, Busy <= 0, state <= DONE.
- Latency: Start accepted at edge k gives Valid=1 and the new Bcd after edge k+WIDTH (17 cycles at the default).
- Start while in SHIFT: ignored. Bin is not re-sampled, and the in-flight conversion is unaffected.
- DONE:
  - Bcd and Valid hold.
  - Start=1 behaves as in IDLE: Valid <= 0 and Busy <= 1 on that edge, while Bcd keeps the old value until the new conversion completes.
- Bin changing while not accepted: no effect.
- Reset mid-SHIFT: conversion is aborted and all outputs return to reset values on that edge.
- Arithmetic:
  - Scratch width is 4*DIGITS.
  - The add-3 is per nibble and cannot carry between nibbles (a nibble <= 9 before shift never exceeds 15 after +3).
  - No saturation or overflow output is needed under the parameter constraint.
- Busy and Valid are never both 1.
- Bcd changes only on the completion edge or on reset.

Test Plan:
- Reset, then idle 5 cycles -> Busy=0, Valid=0, Bcd=24'h000000 throughout.
- Start pulse with Bin=0 -> Busy high 17 cycles; Valid=1 after edge k+17; Bcd=24'h000000.
- Bin=131071 (17'h1FFFF) -> Bcd=24'h131071 after 17 cycles. Then Bin=99999 -> 24'h099999, with Bcd holding 24'h131071 until the second completion.
- Bin=12345, then Start re-asserted at cycles k+3 and k+10 with Bin=7 -> both ignored; result 24'h012345 at k+17.
- Bin=50000, Reset asserted at cycle k+8 -> next edge gives Busy=0, Valid=0, Bcd=0, state IDLE. A following Start with Bin=9 -> Bcd=24'h000009.
- Random regression: 1000 random Bin values in [0, 131071] -> Bcd digits equal a decimal reference model; latency is exactly 17 cycles on every conversion.

Source files
------------

// File: rtl/result_bcd_converter_if.sv
// Handshake bundle between the calculator result path and the BCD converter.
//   Start : request conversion of Bin (requester -> converter)
//   Bin   : binary value to convert (requester -> converter)
//   Busy  : conversion in progress (converter -> requester)
//   Valid : Bcd holds a completed result, level (converter -> requester)
//   Bcd   : packed BCD digits, Bcd[3:0] = ones (converter -> requester)
interface result_bcd_converter_if #(
  parameter int WIDTH  = 17,
  parameter int DIGITS = 6
);
  logic                  Start;
  logic [WIDTH-1:0]      Bin;
  logic                  Busy;
  logic                  Valid;
  logic [4*DIGITS-1:0]   Bcd;

  modport master (output Start, Bin, input Busy, Valid, Bcd);
  modport slave  (input Start, Bin, output Busy, Valid, Bcd);
endinterface

// File: rtl/result_bcd_converter.sv
// Sequential double-dabble binary->BCD converter, one input bit per clock.
// A conversion accepted on edge k completes on edge k+WIDTH; the last
// completed result stays on Bcd until the next conversion finishes.
//   Clk   : system clock, rising edge
//   Reset : synchronous, active-high
//   bus   : slave side of result_bcd_converter_if (Start/Bin in,
//           Busy/Valid/Bcd out)

// Per-digit add-3 correction applied before each shift.
module bcd_nibble_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module result_bcd_converter #(
  parameter int WIDTH  = 17,
  parameter int DIGITS = 6
) (
  input  logic                 Clk,
  input  logic                 Reset,
  result_bcd_converter_if.slave bus
);
  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   scr, scr_nxt, scr_adj;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [SW-1:0]   bcd_q, bcd_nxt;

  // All digits corrected in parallel; a digit <= 9 never exceeds 15 after
  // +3, so no carry crosses nibble boundaries.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_nibble_adj u_adj (.d(scr[4*g +: 4]), .q(scr_adj[4*g +: 4]));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      scr   <= '0;
      sr    <= '0;
      cnt   <= '0;
      bcd_q <= '0;
    end else begin
      state <= state_nxt;
      scr   <= scr_nxt;
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
      bcd_q <= bcd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    scr_nxt   = scr;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    bcd_nxt   = bcd_q;
    case (state)
      IDLE, DONE: begin
        // Bcd is not touched here so the old result stays visible.
        if (bus.Start) begin
          scr_nxt   = '0;
          sr_nxt    = bus.Bin;
          cnt_nxt   = CW'(WIDTH);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // Start is deliberately not looked at here.
        {scr_nxt, sr_nxt} = {scr_adj[SW-2:0], sr, 1'b0};
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          bcd_nxt   = scr_nxt;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.Busy  = (state == SHIFT);
  assign bus.Valid = (state == DONE);
  assign bus.Bcd   = bcd_q;

  // The top scratch bit is dropped by the shift; with 10^DIGITS > 2^WIDTH it
  // can never be set after the adjust.
  a_no_overflow: assert property (@(posedge Clk) disable iff (Reset)
    (state == SHIFT) |-> !scr_adj[SW-1]);
endmodule
